bcd_seq_multiplier: RTL

Parametrised sequential shift-add multiplier with integrated multi-cycle double-dabble binary-to-BCD conversion. Accepts two N-bit operands on a start handshake, produces a 2N-bit binary product and its packed BCD representation, and flags completion with a level `finish`. It is the arithmetic core feeding the BCD display/readout path, replacing the fixed 8-bit unit with a configurable-width, restartable, optionally signed block.

---
 rtl/bcd_seq_multiplier.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/bcd_seq_multiplier.sv
// ---------------------------------------------------------------------------
// bcd_seq_multiplier : shift-add multiplier with multi-cycle double-dabble BCD
// conversion. Optional two's-complement operands via BCD_SIGNED_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_seq_multiplier #(
  parameter int N      = 8,
  parameter int DIGITS = 5   // 10**DIGITS must cover 2**(2*N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [N-1:0]          a_in,
  input  logic [N-1:0]          b_in,
  output logic                  busy,
  output logic                  finish,
  output logic [2*N-1:0]        out,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  sign
);

  localparam int CW = $clog2(2*N+1);
  localparam logic [CW-1:0] C_MUL_CNT  = CW'(N);
  localparam logic [CW-1:0] C_CONV_CNT = CW'(2*N);
  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [2*N-1:0]        mcand_q, mcand_d;
  logic [N-1:0]          mplier_q, mplier_d;
  logic [2*N-1:0]        acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [4*DIGITS-1:0]   bcd_adj;
  logic [2*N-1:0]        out_q, out_d;
  logic                  busy_q, busy_d;
  logic                  finish_q, finish_d;
  logic [N-1:0]          op_a, op_b;

`ifdef BCD_SIGNED_EN
  logic neg_q, neg_d;
  logic sign_q, sign_d;

  // Magnitude of -2**(N-1) is 2**(N-1), which still fits N unsigned bits.
  assign op_a = a_in[N-1] ? ((~a_in) + N'(1)) : a_in;
  assign op_b = b_in[N-1] ? ((~b_in) + N'(1)) : b_in;
`else
  assign op_a = a_in;
  assign op_b = b_in;
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    out_d    = out_q;
    busy_d   = busy_q;
    finish_d = finish_q;
    bcd_adj  = bcd_q;
`ifdef BCD_SIGNED_EN
    neg_d    = neg_q;
    sign_d   = sign_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d  = {{N{1'b0}}, op_a};
          mplier_d = op_b;
          acc_d    = '0;
          bcd_d    = '0;
          cnt_d    = C_MUL_CNT;
          busy_d   = 1'b1;
          finish_d = 1'b0;
          state_d  = MUL;
`ifdef BCD_SIGNED_EN
          neg_d    = a_in[N-1] ^ b_in[N-1];
`endif
        end
      end

      MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - C_CNT_ONE;
        if (cnt_q == C_CNT_ONE) begin
          cnt_d   = C_CONV_CNT;
          state_d = CONV;
        end
      end

      CONV: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_d = {bcd_adj[4*DIGITS-2:0], acc_q[2*N-1]};
        // Rotating the accumulator feeds bits MSB first and restores the
        // product after exactly 2N steps, so no separate shift copy is needed.
        acc_d = {acc_q[2*N-2:0], acc_q[2*N-1]};
        cnt_d = cnt_q - C_CNT_ONE;
        if (cnt_q == C_CNT_ONE) begin
          state_d  = DONE;
          busy_d   = 1'b0;
          finish_d = 1'b1;
`ifdef BCD_SIGNED_EN
          out_d    = neg_q ? ((~acc_d) + (2*N)'(1)) : acc_d;
          sign_d   = neg_q && (acc_d != '0);
`else
          out_d    = acc_d;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      bcd_q    <= '0;
      out_q    <= '0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
`ifdef BCD_SIGNED_EN
      neg_q    <= 1'b0;
      sign_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      bcd_q    <= bcd_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      finish_q <= finish_d;
`ifdef BCD_SIGNED_EN
      neg_q    <= neg_d;
      sign_q   <= sign_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign finish = finish_q;
  assign out    = out_q;
  assign bcd    = bcd_q;
`ifdef BCD_SIGNED_EN
  assign sign   = sign_q;
`else
  assign sign   = 1'b0;
`endif

endmodule

`default_nettype wire
